// File: rtl/winner_decoder.sv
// winner_decoder: debounces the fastest-finger code, latches the first winner, drives LEDs and buzzer
module winner_decoder #(
    parameter int N_CONT       = 10,
    parameter int DEBOUNCE_CYC = 4,
    parameter int BUZZ_CYC     = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        binary_in,
    input  logic              arm,
    input  logic              clear,
    output logic [N_CONT-1:0] led_n,
    output logic [3:0]        winner,
    output logic              winner_valid,
    output logic              buzzer,
    output logic              armed
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BUZZ_CYC + 1);
    localparam logic [3:0] NC = 4'(N_CONT);
    localparam logic [N_CONT-1:0] ONE = N_CONT'(1);
    typedef enum logic [1:0] {IDLE, ARMED, DEBOUNCE, LOCKED} state_t;
    state_t state;
    logic [3:0] code_q, cand;
    logic [CW-1:0] cnt;
    logic [BW-1:0] buzz_cnt;
    logic valid, do_lock;
    assign valid = code_q < NC;
    // lock fires straight from ARMED when a single sample suffices, else at the end of a stable run
    always_comb begin
        do_lock = !clear && ((state == ARMED && valid && DEBOUNCE_CYC == 1) ||
                             (state == DEBOUNCE && code_q == cand && cnt == CW'(DEBOUNCE_CYC - 1)));
    end
    // input register, round FSM and registered outputs; clear overrides everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            code_q       <= 4'hF;
            cand         <= 4'hF;
            cnt          <= '0;
            buzz_cnt     <= '0;
            led_n        <= '1;
            winner       <= 4'hF;
            winner_valid <= 1'b0;
            buzzer       <= 1'b0;
            armed        <= 1'b0;
        end else begin
            code_q <= binary_in;
            if (buzzer) begin
                if (buzz_cnt == '0) buzzer <= 1'b0;
                else buzz_cnt <= buzz_cnt - BW'(1);
            end
            if (clear) begin
                state        <= IDLE;
                cnt          <= '0;
                buzz_cnt     <= '0;
                led_n        <= '1;
                winner       <= 4'hF;
                winner_valid <= 1'b0;
                buzzer       <= 1'b0;
                armed        <= 1'b0;
            end else if (do_lock) begin
                state        <= LOCKED;
                cnt          <= '0;
                winner       <= code_q;
                winner_valid <= 1'b1;
                led_n        <= ~(ONE << code_q);
                buzzer       <= 1'b1;
                buzz_cnt     <= BW'(BUZZ_CYC - 1);
                armed        <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (arm) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                    ARMED: if (valid) begin
                        state <= DEBOUNCE;
                        cand  <= code_q;
                        cnt   <= CW'(1);
                    end
                    DEBOUNCE: if (code_q != cand) begin
                        state <= ARMED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_winner_decoder.sv
// tb_winner_decoder: directed checks of debounce, lock, buzzer timing, clear and async reset
module tb_winner_decoder;
    logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, clear = 1'b0;
    logic [3:0] binary_in = 4'hF;
    logic [9:0] led_n;
    logic [3:0] winner;
    logic winner_valid, buzzer, armed;
    int passed = 0, failed = 0, total = 0;

    winner_decoder dut (
        .clk(clk), .rst_n(rst_n), .binary_in(binary_in), .arm(arm), .clear(clear),
        .led_n(led_n), .winner(winner), .winner_valid(winner_valid),
        .buzzer(buzzer), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, " led_n"}, 32'(led_n), 32'h3FF);
        check({tag, " winner"}, 32'(winner), 32'hF);
        check({tag, " valid"}, 32'(winner_valid), 0);
        check({tag, " buzzer"}, 32'(buzzer), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    initial begin
        tick(2);
        idle_outputs("reset");
        check("reset armed", 32'(armed), 0);
        rst_n = 1'b1;
        tick(1);

        // 1: code 0 held, lock after edge 5, buzzer exactly 50 cycles
        do_arm();
        check("t1 armed", 32'(armed), 1);
        binary_in = 4'd0;
        tick(4);
        check("t1 no lock edge4", 32'(winner_valid), 0);
        tick(1);
        check("t1 valid edge5", 32'(winner_valid), 1);
        check("t1 winner", 32'(winner), 0);
        check("t1 led_n", 32'(led_n), 32'h3FE);
        check("t1 buzzer on", 32'(buzzer), 1);
        check("t1 armed off", 32'(armed), 0);
        tick(49);
        check("t1 buzzer cycle50", 32'(buzzer), 1);
        tick(1);
        check("t1 buzzer off", 32'(buzzer), 0);
        check("t1 valid held", 32'(winner_valid), 1);
        do_clear();
        binary_in = 4'hF;
        idle_outputs("t1 clear");

        // 2: bounce on 3 then settle on 7
        do_arm();
        binary_in = 4'd3;
        tick(2);
        binary_in = 4'd7;
        tick(5);
        check("t2 no lock yet", 32'(winner_valid), 0);
        check("t2 still armed", 32'(armed), 1);
        tick(1);
        check("t2 valid", 32'(winner_valid), 1);
        check("t2 winner", 32'(winner), 7);
        check("t2 led_n", 32'(led_n), 32'h37F);
        do_clear();
        binary_in = 4'hF;

        // 3: locked winner ignores later presses; clear restores idle outputs
        do_arm();
        binary_in = 4'd2;
        tick(5);
        check("t3 winner", 32'(winner), 2);
        binary_in = 4'd0;
        arm = 1'b1;
        tick(6);
        arm = 1'b0;
        check("t3 winner held", 32'(winner), 2);
        check("t3 led_n held", 32'(led_n), 32'h3FB);
        do_clear();
        idle_outputs("t3 clear");
        check("t3 armed", 32'(armed), 0);
        binary_in = 4'hF;

        // 4: out-of-range codes never lock
        do_arm();
        binary_in = 4'd12;
        tick(10);
        check("t4 armed c12", 32'(armed), 1);
        check("t4 valid c12", 32'(winner_valid), 0);
        binary_in = 4'd10;
        tick(8);
        check("t4 armed c10", 32'(armed), 1);
        check("t4 valid c10", 32'(winner_valid), 0);
        binary_in = 4'hF;
        tick(8);
        idle_outputs("t4 cF");
        check("t4 armed cF", 32'(armed), 1);
        do_clear();
        check("t4 cleared", 32'(armed), 0);

        // 5: clear beats arm; clear truncates buzzer
        arm = 1'b1;
        clear = 1'b1;
        tick(2);
        check("t5 arm&clear", 32'(armed), 0);
        clear = 1'b0;
        arm = 1'b0;
        do_arm();
        binary_in = 4'd5;
        tick(5);
        check("t5 locked", 32'(winner), 5);
        tick(9);
        check("t5 buzzer cycle10", 32'(buzzer), 1);
        do_clear();
        check("t5 buzzer cut", 32'(buzzer), 0);
        check("t5 valid", 32'(winner_valid), 0);
        tick(3);
        check("t5 buzzer stays off", 32'(buzzer), 0);
        binary_in = 4'hF;

        // 6: async reset mid-DEBOUNCE and mid-LOCKED
        do_arm();
        binary_in = 4'd4;
        tick(3);
        check("t6 debouncing", 32'(armed), 1);
        #2 rst_n = 1'b0;
        #1 check("t6 async armed", 32'(armed), 0);
        tick(1);
        rst_n = 1'b1;
        tick(8);
        check("t6 needs arm", 32'(armed), 0);
        check("t6 no lock", 32'(winner_valid), 0);
        do_arm();
        tick(4);
        check("t6 relock", 32'(winner), 4);
        check("t6 relock led", 32'(led_n), 32'h3EF);
        #2 rst_n = 1'b0;
        #1 idle_outputs("t6 async locked");
        tick(1);
        rst_n = 1'b1;
        binary_in = 4'hF;
        tick(2);
        idle_outputs("t6 after release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
